// File: rtl/io_bridge_pkg.sv
// Shared constants for the processor I/O bridge: default port counts,
// interrupt FSM encoding and a small slot-address helper.
package io_bridge_pkg;

    localparam int NBIOIN_DEF = 2;
    localparam int NBIOOU_DEF = 2;
    localparam int NPIN       = 2 ** NBIOIN_DEF;
    localparam int NPOUT      = 2 ** NBIOOU_DEF;

    // Interrupt FSM encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // True when a processor read address selects the given slot
    function automatic logic slot_hit(input int unsigned addr, input int unsigned slot);
        return addr == slot;
    endfunction

endpackage

// File: rtl/io_in_slot.sv
// One-word holding slot for a single input port.
// Handshake: a word moves from the peripheral into the slot on a rising edge
// where p_vld and rdy are both 1; while rdy is 0 the peripheral keeps p_in
// and p_vld stable. rdy is 1 when the slot is empty or is being read in the
// same cycle, so a read and a refill can happen on the same edge.
module io_in_slot
    import io_bridge_pkg::*;
#(
    parameter int NUBITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] p_in,
    input  logic              p_vld,
    input  logic              rd_hit,
    output logic [NUBITS-1:0] hold,
    output logic              full,
    output logic              rdy
);

    // Slot accepts when empty or when the current word is being consumed
    always_comb rdy = ~full | rd_hit;

    // Capture has priority over the read so a bypass refill keeps the slot full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            full <= 1'b0;
        end else if (p_vld && rdy) begin
            hold <= p_in;
            full <= 1'b1;
        end else if (rd_hit) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// Peripheral-side responder for the processor I/O bus: latched output
// registers with write strobes, input holding slots with valid/ready, and a
// one-shot interrupt raised when enabled input data is pending.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NBIOIN = NBIOIN_DEF,
    parameter int NBIOOU = NBIOOU_DEF,
    parameter logic [2**NBIOIN-1:0] ITR_EN = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUBITS-1:0]             io_out,
    input  logic [NBIOOU-1:0]             addr_out,
    input  logic                          out_en,
    input  logic [NBIOIN-1:0]             addr_in,
    input  logic                          req_in,
    output logic [NUBITS-1:0]             io_in,
    output logic                          itr,
    output logic [NUBITS*(2**NBIOOU)-1:0] p_out,
    output logic [2**NBIOOU-1:0]          p_stb,
    input  logic [NUBITS*(2**NBIOIN)-1:0] p_in,
    input  logic [2**NBIOIN-1:0]          p_vld,
    output logic [2**NBIOIN-1:0]          p_rdy,
    output logic [2**NBIOIN-1:0]          p_full,
    output logic [1:0]                    state_dbg
);

    localparam int NPI = 2 ** NBIOIN;
    localparam int NPO = 2 ** NBIOOU;

    logic [NUBITS-1:0] out_reg  [NPO];
    logic [NUBITS-1:0] hold_arr [NPI];
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              pend;

    // Write path: latch the addressed output port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NPO; k++) out_reg[k] <= '0;
        end else if (out_en) begin
            out_reg[addr_out] <= io_out;
        end
    end

    // Write strobe: one-cycle pulse on the port written at the previous edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_stb <= '0;
        else if (out_en) p_stb <= {{(NPO-1){1'b0}}, 1'b1} << addr_out;
        else p_stb <= '0;
    end

    for (genvar k = 0; k < NPO; k++) begin : g_out
        assign p_out[k*NUBITS +: NUBITS] = out_reg[k];
    end

    for (genvar p = 0; p < NPI; p++) begin : g_slot
        io_in_slot #(.NUBITS(NUBITS)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .p_in   (p_in[p*NUBITS +: NUBITS]),
            .p_vld  (p_vld[p]),
            .rd_hit (req_in & slot_hit(32'(addr_in), p)),
            .hold   (hold_arr[p]),
            .full   (p_full[p]),
            .rdy    (p_rdy[p])
        );
    end

    // Read mux: zero-latency view of the addressed slot, full or not
    always_comb io_in = hold_arr[addr_in];

    // Any enabled slot holding unread data requests attention
    always_comb pend = |(p_full & ITR_EN);

    // Interrupt FSM next state: one pulse per rise of pend
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pend) state_nxt = ST_PULSE;
            ST_PULSE: state_nxt = ST_WAIT;
            ST_WAIT:  if (!pend) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Interrupt FSM state and registered itr, high only while in PULSE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            itr   <= 1'b0;
        end else begin
            state <= state_nxt;
            itr   <= (state_nxt == ST_PULSE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a 4-in/4-out, 16-bit configuration and
// only input port 1 enabled for interrupts.
module tb_io_bridge;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  io_out;
    logic [1:0]    addr_out;
    logic          out_en;
    logic [1:0]    addr_in;
    logic          req_in;
    logic [W-1:0]  io_in;
    logic          itr;
    logic [4*W-1:0] p_out;
    logic [3:0]    p_stb;
    logic [4*W-1:0] p_in;
    logic [3:0]    p_vld;
    logic [3:0]    p_rdy;
    logic [3:0]    p_full;
    logic [1:0]    state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    io_bridge #(.NUBITS(W), .NBIOIN(2), .NBIOOU(2), .ITR_EN(4'b0010)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_out    (io_out),
        .addr_out  (addr_out),
        .out_en    (out_en),
        .addr_in   (addr_in),
        .req_in    (req_in),
        .io_in     (io_in),
        .itr       (itr),
        .p_out     (p_out),
        .p_stb     (p_stb),
        .p_in      (p_in),
        .p_vld     (p_vld),
        .p_rdy     (p_rdy),
        .p_full    (p_full),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver helpers
    task automatic set_in(input int p, input logic [W-1:0] d);
        p_in[p*W +: W] = d;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; io_out = '0; addr_out = '0; out_en = 1'b0;
        addr_in = '0; req_in = 1'b0; p_in = '0; p_vld = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_p_out", 64'(p_out), 64'h0);
        check("rst_p_stb", 64'(p_stb), 64'h0);
        check("rst_p_full", 64'(p_full), 64'h0);
        check("rst_p_rdy", 64'(p_rdy), 64'hF);
        check("rst_itr", 64'(itr), 64'h0);
        check("rst_io_in", 64'(io_in), 64'h0);
        check("rst_state", 64'(state_dbg), 64'h0);

        // Writes
        out_en = 1'b1; addr_out = 2'd2; io_out = 16'hBEEF;
        tick();
        out_en = 1'b0;
        check("wr_p_out2", 64'(p_out[2*W +: W]), 64'hBEEF);
        check("wr_stb", 64'(p_stb), 64'h4);
        tick();
        check("wr_stb_gone", 64'(p_stb), 64'h0);
        out_en = 1'b1; addr_out = 2'd3; io_out = 16'h1234;
        tick();
        addr_out = 2'd2; io_out = 16'h5678;
        check("b2b_stb3", 64'(p_stb), 64'h8);
        tick();
        out_en = 1'b0;
        check("b2b_stb2", 64'(p_stb), 64'h4);
        check("b2b_p_out", 64'(p_out), 64'h1234_5678_0000_0000);
        tick();
        check("b2b_stb_gone", 64'(p_stb), 64'h0);

        // Input capture on port 1 (interrupt-enabled)
        p_vld = 4'b0010; set_in(1, 16'h0123);
        #1;
        check("cap_rdy_before", 64'(p_rdy[1]), 64'h1);
        tick();
        p_vld = '0;
        check("cap_full", 64'(p_full), 64'h2);
        check("cap_rdy", 64'(p_rdy), 64'hD);
        check("cap_itr_not_yet", 64'(itr), 64'h0);
        addr_in = 2'd1;
        #1;
        check("cap_io_in", 64'(io_in), 64'h0123);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        check("rd_full_clr", 64'(p_full), 64'h0);
        check("rd_itr_pulse", 64'(itr), 64'h1);
        check("rd_empty_last", 64'(io_in), 64'h0123);
        tick();
        check("rd_itr_drop", 64'(itr), 64'h0);
        check("rd_state_wait", 64'(state_dbg), 64'h2);
        tick();
        check("rd_state_idle", 64'(state_dbg), 64'h0);

        // Same-cycle read/refill bypass on port 0 (not interrupt-enabled)
        p_vld = 4'b0001; set_in(0, 16'h0011);
        tick();
        p_vld = '0;
        check("byp_full0", 64'(p_full), 64'h1);
        addr_in = 2'd0; req_in = 1'b1; p_vld = 4'b0001; set_in(0, 16'h0022);
        #1;
        check("byp_io_old", 64'(io_in), 64'h0011);
        check("byp_rdy0", 64'(p_rdy[0]), 64'h1);
        tick();
        req_in = 1'b0; p_vld = '0;
        check("byp_io_new", 64'(io_in), 64'h0022);
        check("byp_full_kept", 64'(p_full[0]), 64'h1);
        tick();
        check("itr_masked0", 64'(itr), 64'h0);
        check("itr_masked_state", 64'(state_dbg), 64'h0);

        // Interrupt sequencing on port 1
        p_vld = 4'b0010; set_in(1, 16'h0A01);
        tick();
        p_vld = '0;
        check("itr_wait1", 64'(itr), 64'h0);
        tick();
        check("itr_pulse1", 64'(itr), 64'h1);
        addr_in = 2'd1; req_in = 1'b1; p_vld = 4'b0010; set_in(1, 16'h0A02);
        tick();
        req_in = 1'b0; p_vld = '0;
        check("itr_refill_nopulse", 64'(itr), 64'h0);
        check("itr_refill_word", 64'(io_in), 64'h0A02);
        tick();
        check("itr_wait_nopulse", 64'(itr), 64'h0);
        tick();
        check("itr_wait_state", 64'(state_dbg), 64'h2);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        check("itr_rd_full", 64'(p_full[1]), 64'h0);
        check("itr_rd_state", 64'(state_dbg), 64'h2);
        tick();
        check("itr_back_idle", 64'(state_dbg), 64'h0);
        p_vld = 4'b0010; set_in(1, 16'h0A03);
        tick();
        p_vld = '0;
        tick();
        check("itr_pulse2", 64'(itr), 64'h1);
        tick();
        check("itr_pulse2_end", 64'(itr), 64'h0);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        tick();
        check("itr_final_idle", 64'(state_dbg), 64'h0);

        // Backpressure on port 3
        p_vld = 4'b1000; set_in(3, 16'h3001); exp_q.push_back(16'h3001);
        tick();
        set_in(3, 16'h3002);
        #1;
        check("bp_rdy_low", 64'(p_rdy[3]), 64'h0);
        tick();
        set_in(3, 16'h3003);
        tick();
        addr_in = 2'd3;
        #1;
        exp_w = exp_q.pop_front();
        check("bp_hold_first", 64'(io_in), 64'(exp_w));
        check("bp_full", 64'(p_full[3]), 64'h1);
        req_in = 1'b1; set_in(3, 16'h3004); exp_q.push_back(16'h3004);
        #1;
        check("bp_rdy_bypass", 64'(p_rdy[3]), 64'h1);
        tick();
        req_in = 1'b0; p_vld = '0; set_in(3, 16'h3005);
        #1;
        exp_w = exp_q.pop_front();
        check("bp_captured", 64'(io_in), 64'(exp_w));
        check("bp_full_kept", 64'(p_full), 64'h9);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_p_out", 64'(p_out), 64'h0);
        check("arst_p_full", 64'(p_full), 64'h0);
        check("arst_itr", 64'(itr), 64'h0);
        check("arst_io_in", 64'(io_in), 64'h0);
        check("arst_state", 64'(state_dbg), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_release_rdy", 64'(p_rdy), 64'hF);
        check("arst_release_stb", 64'(p_stb), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
